register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the core's integer register file, for the pipelined riscx core.
- Provides configurable width and depth, two combinational read ports and one write port, plus an asynchronous reset that restores architectural init values.
- Adds optional write-to-read bypass and a per-register busy scoreboard that decode uses to stall on pending writebacks.
- Sits between decode (read, issue) and writeback (write, retire).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS)
SP_INDEX, 2, register loaded with SP_INIT on reset
SP_INIT, 32'h3fc, stack-pointer reset value (255*4)
BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports; 0 = visible next cycle

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rs1  in  AW  read port 1 address
rs2  in  AW  read port 2 address
registerRead1  out  XLEN  read port 1 data
registerRead2  out  XLEN  read port 2 data
busy1  out  1  rs1 has a pending write
busy2  out  1  rs2 has a pending write
writeRegister  in  1  writeback strobe
rd  in  AW  writeback address
dataToWrite  in  XLEN  writeback data
issueValid  in  1  decode issued an instruction that will write issueRd
issueRd  in  AW  destination of the issued instruction
pendingCount  out  AW+1  number of registers currently busy
watchSelect  in  AW  debug watch address
watch  out  XLEN  contents of register watchSelect (no bypass)

Behaviour:
- Reset (async assert, sync release to the next clock edge):
  - All registers go to 0, except register SP_INDEX, which goes to SP_INIT.
  - All busy bits clear; pendingCount = 0.
  - Outputs reflect the reset state combinationally while reset is high.
  - Any write or issue present during reset is discarded.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to rd/issueRd = 0 are ignored; they do not change pendingCount.
- Write:
  - On a rising clock edge with writeRegister=1 and rd!=0, registers[rd] <= dataToWrite.
  - Busy bit rd clears, unless the set rule below applies.
- Read:
  - registerReadN = registers[rsN], combinational.
  - If BYPASS=1, writeRegister=1, rd=rsN and rd!=0, registerReadN = dataToWrite (0-cycle forward).
  - If BYPASS=0, the written value appears the cycle after the edge.
- Scoreboard:
  - On a rising edge with issueValid=1 and issueRd!=0, busy[issueRd] <= 1.
  - Same edge, same register, with both issue and writeback: busy ends set (the new writer wins) and the data is written.
  - Issue and writeback to different registers: both take effect.
  - Issue to a register already busy: it stays busy, and pendingCount does not double-count.
  - Writeback to a non-busy register: the data is written and busy stays 0.
- Busy outputs:
  - busyN = busy[rsN], forced 0 when rsN=0.
  - If BYPASS=1, busyN also reads 0 in a cycle where writeRegister=1 and rd=rsN (the forwarded data is valid).
  - A same-cycle issue never affects busyN until after the edge.
- pendingCount:
  - Registered population count of the busy bits, updated on the same edge as the busy bits.
  - Range 0..NREGS-1.
- watch: registers[watchSelect], combinational, register contents only (no bypass).
- Timing: single cycle; no internal state machine beyond the register array and busy vector.
- Reset mid-operation: an in-flight write on the same edge as reset assertion is lost; the scoreboard clears.

Test Plan:
- Assert reset, then release -> registerRead1 with rs1=2 reads 32'h3fc; rs1=5 reads 0; pendingCount=0; busy1=busy2=0.
- Write rd=7, data 32'hDEADBEEF, with rs1=7, BYPASS=1 -> registerRead1 = 32'hDEADBEEF in the same cycle, and stays so after the edge. Repeat with BYPASS=0 -> old value (0) in the write cycle, new value next cycle.
- Write rd=0, data 32'h1234, and issue issueRd=0 -> register 0 reads 0, busy1 (rs1=0) = 0, pendingCount stays 0.
- Issue issueRd=9 -> next cycle busy1 (rs1=9) = 1, pendingCount=1. Writeback rd=9, data 32'h55 -> busy1 = 0 in the same cycle (BYPASS=1), registerRead1 = 32'h55, pendingCount=0 after the edge.
- Same edge: issue issueRd=4 and writeback rd=4, data 32'hA5 -> registers[4]=32'hA5, busy[4]=1, pendingCount=1. Then issue 4 again -> pendingCount stays 1.
- Issue registers 3, 5, 6, then assert reset asynchronously between clock edges with writeRegister=1, rd=3 -> pendingCount=0 and busy outputs clear immediately. Register 3 reads 0 after release; register 2 reads 32'h3fc.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised integer register file for the pipelined riscx core.
// Two combinational read ports, one write port, an optional same-cycle
// write-to-read bypass, and a per-register busy scoreboard. Decode uses the
// scoreboard to stall on writebacks that are still pending.
// Register 0 is hard-wired to zero and is never busy.
module register_file_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h3fc),
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] registerRead1,
  output logic [XLEN-1:0] registerRead2,
  output logic            busy1,
  output logic            busy2,
  input  logic            writeRegister,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] dataToWrite,
  input  logic            issueValid,
  input  logic [AW-1:0]   issueRd,
  output logic [AW:0]     pendingCount,
  input  logic [AW-1:0]   watchSelect,
  output logic [XLEN-1:0] watch
);

  // Architectural state, viewed as an array for the read muxes.
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      pending_next;
  logic [AW:0]      pending;

  // Writes and issues aimed at register 0 are dropped right here, so they
  // can neither change data nor disturb the scoreboard or its count.
  logic write_ok;
  logic issue_ok;
  assign write_ok = writeRegister && (rd != '0);
  assign issue_ok = issueValid && (issueRd != '0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs[gi]      = '0;
      assign busy[gi]      = 1'b0;
      assign busy_next[gi] = 1'b0;
    end else begin : g_live
      logic [XLEN-1:0] value;
      logic            busy_bit;
      logic            wr_sel;
      logic            is_sel;

      assign wr_sel = write_ok && (rd == AW'(gi));
      assign is_sel = issue_ok && (issueRd == AW'(gi));

      // Data register: async reset to its init value, load on writeback.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          value <= (gi == SP_INDEX) ? SP_INIT : '0;
        end else if (wr_sel) begin
          value <= dataToWrite;
        end
      end

      // An issue on the same edge as the retiring write belongs to a newer
      // instruction, so the set takes priority over the clear.
      assign busy_next[gi] = is_sel ? 1'b1 : (wr_sel ? 1'b0 : busy_bit);

      // Scoreboard bit for this register.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          busy_bit <= 1'b0;
        end else begin
          busy_bit <= busy_next[gi];
        end
      end

      assign regs[gi] = value;
      assign busy[gi] = busy_bit;
    end
  end

  // Population count of the next busy vector, so the registered count moves
  // on the same edge as the busy bits themselves.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_next = pending_next + (AW + 1)'(busy_next[i]);
    end
  end

  // Registered pending-writeback count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Forwarding hits: the write being presented this cycle targets the read
  // address. Suppressed during reset so outputs show the reset state only.
  logic fwd1;
  logic fwd2;
  if (BYPASS != 0) begin : g_bypass
    assign fwd1 = write_ok && !reset && (rd == rs1);
    assign fwd2 = write_ok && !reset && (rd == rs2);
  end else begin : g_no_bypass
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
  end

  // Forwarded data is valid, so the matching busy flag drops in that cycle.
  assign registerRead1 = fwd1 ? dataToWrite : regs[rs1];
  assign registerRead2 = fwd2 ? dataToWrite : regs[rs2];
  assign busy1         = busy[rs1] && !fwd1;
  assign busy2         = busy[rs2] && !fwd2;
  assign pendingCount  = pending;
  assign watch         = regs[watchSelect];

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: one bypass and one non-bypass instance
// share stimulus; a behavioural register/scoreboard model predicts outputs.
module tb_register_file_sb;

  logic        clock;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, issueRd, watchSelect;
  logic        writeRegister, issueValid;
  logic [31:0] dataToWrite;

  logic [31:0] rr1_b, rr2_b, watch_b, rr1_n, rr2_n, watch_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  logic [5:0]  pend_b, pend_n;

  register_file_sb #(.BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
    .registerRead1(rr1_b), .registerRead2(rr2_b),
    .busy1(busy1_b), .busy2(busy2_b),
    .writeRegister(writeRegister), .rd(rd), .dataToWrite(dataToWrite),
    .issueValid(issueValid), .issueRd(issueRd),
    .pendingCount(pend_b), .watchSelect(watchSelect), .watch(watch_b)
  );

  register_file_sb #(.BYPASS(0)) dut_n (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
    .registerRead1(rr1_n), .registerRead2(rr2_n),
    .busy1(busy1_n), .busy2(busy2_n),
    .writeRegister(writeRegister), .rd(rd), .dataToWrite(dataToWrite),
    .issueValid(issueValid), .issueRd(issueRd),
    .pendingCount(pend_n), .watchSelect(watchSelect), .watch(watch_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural contents and the set of pending writers.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_regs[2] = 32'h3fc;
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && !reset && writeRegister && rd == a) return dataToWrite;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && !reset && writeRegister && rd == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Compare every output of both instances against the model.
  task automatic check_all();
    check("rd1_byp", rr1_b, exp_read(rs1, 1'b1));
    check("rd2_byp", rr2_b, exp_read(rs2, 1'b1));
    check("busy1_byp", 32'(busy1_b), 32'(exp_busy(rs1, 1'b1)));
    check("busy2_byp", 32'(busy2_b), 32'(exp_busy(rs2, 1'b1)));
    check("pend_byp", 32'(pend_b), 32'(model_pending()));
    check("watch_byp", watch_b, m_regs[watchSelect]);
    check("rd1_nobyp", rr1_n, exp_read(rs1, 1'b0));
    check("rd2_nobyp", rr2_n, exp_read(rs2, 1'b0));
    check("busy1_nobyp", 32'(busy1_n), 32'(exp_busy(rs1, 1'b0)));
    check("busy2_nobyp", 32'(busy2_n), 32'(exp_busy(rs2, 1'b0)));
    check("pend_nobyp", 32'(pend_n), 32'(model_pending()));
    check("watch_nobyp", watch_n, m_regs[watchSelect]);
  endtask

  // Apply one cycle's inputs (called just after a falling edge), then check.
  task automatic drive(input bit rst, input bit w, input logic [4:0] a_rd,
                       input logic [31:0] d, input bit iv, input logic [4:0] a_is,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ws);
    reset = rst; writeRegister = w; rd = a_rd; dataToWrite = d;
    issueValid = iv; issueRd = a_is; rs1 = a1; rs2 = a2; watchSelect = ws;
    if (rst) model_reset();
    #1;
    check_all();
  endtask

  // Advance across one rising edge, updating the model as the spec dictates.
  task automatic edge_step();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (writeRegister && rd != 0) begin
        m_regs[rd] = dataToWrite;
        m_busy[rd] = 1'b0;
      end
      if (issueValid && issueRd != 0) m_busy[issueRd] = 1'b1;
    end
    $display("[TB] t=%0t rst=%0b wr=%0b rd=%0d data=%h iss=%0b ird=%0d pend=%0d",
             $time, reset, writeRegister, rd, dataToWrite, issueValid, issueRd, model_pending());
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; writeRegister = 0; rd = 0; dataToWrite = 0;
    issueValid = 0; issueRd = 0; rs1 = 0; rs2 = 0; watchSelect = 0;
    model_reset();
    @(negedge clock);
    edge_step();

    // Release reset: SP init and zeros visible.
    drive(0, 0, 0, 0, 0, 0, 5'd2, 5'd5, 5'd2);
    check("rst_sp", rr1_b, 32'h3fc);
    check("rst_r5", rr2_b, 32'h0);
    check("rst_pend", 32'(pend_b), 32'd0);
    check("rst_busy", 32'({busy1_b, busy2_b}), 32'd0);
    edge_step();

    // Write 7: forwarded with bypass, one cycle late without.
    drive(0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 5'd7, 5'd0, 5'd7);
    check("byp_same", rr1_b, 32'hDEADBEEF);
    check("nobyp_same", rr1_n, 32'h0);
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd7);
    check("byp_after", rr1_b, 32'hDEADBEEF);
    check("nobyp_after", rr1_n, 32'hDEADBEEF);
    edge_step();

    // Register 0 ignores writes and issues.
    drive(0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 5'd0, 5'd0);
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("r0_read", rr1_b, 32'h0);
    check("r0_busy", 32'(busy1_b), 32'd0);
    check("r0_pend", 32'(pend_b), 32'd0);
    edge_step();

    // Issue 9, then write it back.
    drive(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 5'd9);
    check("iss_nosame", 32'(busy1_b), 32'd0);
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd0, 5'd9);
    check("iss9_busy", 32'(busy1_b), 32'd1);
    check("iss9_pend", 32'(pend_b), 32'd1);
    edge_step();
    drive(0, 1, 5'd9, 32'h55, 0, 0, 5'd9, 5'd0, 5'd9);
    check("wb9_busy_byp", 32'(busy1_b), 32'd0);
    check("wb9_busy_nobyp", 32'(busy1_n), 32'd1);
    check("wb9_data", rr1_b, 32'h55);
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd0, 5'd9);
    check("wb9_pend", 32'(pend_b), 32'd0);
    edge_step();

    // Same-edge issue and writeback to 4; then re-issue 4.
    drive(0, 1, 5'd4, 32'hA5, 1, 5'd4, 5'd0, 5'd0, 5'd4);
    edge_step();
    drive(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 5'd4);
    check("same4_data", rr1_n, 32'hA5);
    check("same4_busy", 32'(busy1_n), 32'd1);
    check("same4_pend", 32'(pend_b), 32'd1);
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd4, 5'd0, 5'd4);
    check("reiss4_pend", 32'(pend_b), 32'd1);
    edge_step();

    // Issue 3, 5, 6, then async reset between edges with a write to 3 pending.
    drive(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd5, 5'd3);
    edge_step();
    drive(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 5'd3);
    edge_step();
    drive(0, 0, 0, 0, 1, 5'd6, 5'd3, 5'd5, 5'd3);
    edge_step();
    drive(0, 1, 5'd3, 32'hCAFE, 0, 0, 5'd3, 5'd5, 5'd3);
    check("pre_rst_pend", 32'(pend_b), 32'd4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_pend", 32'(pend_b), 32'd0);
    check("async_busy1", 32'(busy1_n), 32'd0);
    check("async_busy2", 32'(busy2_b), 32'd0);
    check("async_rd1", rr1_b, 32'h0);
    check_all();
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd2, 5'd2);
    check("post_r3", rr1_b, 32'h0);
    check("post_sp", rr2_b, 32'h3fc);
    edge_step();

    // Randomized traffic; narrow address range half the time for collisions.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] a[5];
      for (int k = 0; k < 5; k++)
        a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), a[0], $urandom,
            ($urandom_range(0, 2) != 0), a[1], a[2], a[3], a[4]);
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
